// File: rtl/fifo_out.sv
// Output FIFO: stores 128-bit result blocks, returns them as four 32-bit words, most-significant word first.
// Latency: data_out/data_valid one cycle after an accepted read_en; flags are registered from next-state counts.
// Backpressure: writes while full and reads while empty are dropped, flagged by overflow/underflow pulses.
module fifo_out #(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          write_en,
    input  logic [127:0]  data_in,
    input  logic          read_en,
    output logic [31:0]   data_out,
    output logic          data_valid,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [PW+2:0] words_avail,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   BLK_ONE  = 1;
    localparam logic [PW:0]   BLK_FULL = (PW+1)'(DEPTH);
    localparam logic [PW+2:0] WRD_ONE  = 1;
    localparam logic [PW+2:0] WRD_FOUR = 4;

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   blk_cnt;
    logic [PW:0]   blk_nxt;
    logic [1:0]    word_idx;
    logic [PW+2:0] words_nxt;
    logic          wr_acc;
    logic          rd_acc;
    logic          rd_last;
    logic [127:0]  head;
    logic [31:0]   head_word;

    // Accept decisions use the registered flags, so a slot freed this cycle is not reusable until the next.
    assign wr_acc  = write_en & ~fifo_full & ~clear;
    assign rd_acc  = read_en & ~fifo_empty & ~clear;
    assign rd_last = rd_acc & (word_idx == 2'd3);
    assign head    = mem[rd_ptr];

    always_comb begin
        head_word = head[127:96];
        case (word_idx)
            2'd1:    head_word = head[95:64];
            2'd2:    head_word = head[63:32];
            2'd3:    head_word = head[31:0];
            default: head_word = head[127:96];
        endcase
    end

    always_comb begin
        blk_nxt   = blk_cnt;
        words_nxt = words_avail;
        if (wr_acc) begin
            blk_nxt   = blk_nxt + BLK_ONE;
            words_nxt = words_nxt + WRD_FOUR;
        end
        if (rd_acc) begin
            words_nxt = words_nxt - WRD_ONE;
        end
        if (rd_last) begin
            blk_nxt = blk_nxt - BLK_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            blk_cnt     <= '0;
            word_idx    <= '0;
            words_avail <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            blk_cnt     <= '0;
            word_idx    <= '0;
            words_avail <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                data_out <= head_word;
                word_idx <= word_idx + 2'd1;
            end
            if (rd_last) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            blk_cnt     <= blk_nxt;
            words_avail <= words_nxt;
            fifo_full   <= (blk_nxt == BLK_FULL);
            fifo_empty  <= (blk_nxt == '0);
            data_valid  <= rd_acc;
            overflow    <= write_en & fifo_full;
            underflow   <= read_en & fifo_empty;
        end
    end
endmodule

// File: tb/tb_fifo_out.sv
// Bench for fifo_out: word-queue reference model, per-cycle flag checks, and a scoreboard monitor on data_valid.
module tb_fifo_out;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         clear = 1'b0;
    logic         write_en = 1'b0;
    logic [127:0] data_in = '0;
    logic         read_en = 1'b0;
    logic [31:0]  data_out;
    logic         data_valid;
    logic         fifo_empty;
    logic         fifo_full;
    logic [3:0]   words_avail;
    logic         overflow;
    logic         underflow;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_out = '0;
    logic [31:0] mon_exp;
    logic        exp_dv = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_udf = 1'b0;
    int          checks = 0;
    int          failures = 0;

    fifo_out #(.DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .data_valid(data_valid), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .words_avail(words_avail), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // A partially read block still holds its slot, so occupied slots = ceil(words/4).
    function automatic int model_blocks();
        return (mq.size() + 3) / 4;
    endfunction

    task automatic check_state();
        check("words_avail", 32'(words_avail), 32'(mq.size()));
        check("fifo_full", 32'(fifo_full), 32'(model_blocks() == DEPTH));
        check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
        check("data_valid", 32'(data_valid), 32'(exp_dv));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
        check("data_out", data_out, last_out);
    endtask

    task automatic cycle(input bit we, input logic [127:0] din, input bit re, input bit clr);
        bit m_full;
        bit m_empty;
        m_full   = (model_blocks() == DEPTH);
        m_empty  = (mq.size() == 0);
        write_en = we;
        data_in  = din;
        read_en  = re;
        clear    = clr;
        exp_dv   = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        if (clr) begin
            mq.delete();
        end else begin
            if (re && !m_empty) begin
                last_out = mq.pop_front();
                exp_q.push_back(last_out);
                exp_dv = 1'b1;
            end else if (re) begin
                exp_udf = 1'b1;
            end
            if (we && !m_full) begin
                for (int k = 3; k >= 0; k--) mq.push_back(din[32*k +: 32]);
            end else if (we) begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        clear    = 1'b0;
        check_state();
    endtask

    task automatic wr(input logic [127:0] din);
        cycle(1'b1, din, 1'b0, 1'b0);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        last_out = '0;
        exp_dv   = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        check_state();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (n_rst && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected at %0t: got word %h, expected none", $time, data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_word", data_out, mon_exp);
            end
        end
    end

    initial begin
        logic [127:0] blk_a;
        logic [127:0] blk_b;
        logic [127:0] blk_c;
        blk_a = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        blk_b = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
        blk_c = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;

        repeat (2) @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        rd(1);
        wr(128'h00112233_44556677_8899AABB_CCDDEEFF);
        rd(4);

        wr(blk_a);
        wr(blk_b);
        wr(blk_c);
        rd(8);

        wr(blk_a);
        wr(blk_b);
        rd(3);
        cycle(1'b1, blk_c, 1'b1, 1'b0);
        wr(blk_c);
        rd(8);

        wr(blk_a);
        rd(2);
        cycle(1'b1, blk_b, 1'b1, 1'b0);
        rd(5);

        wr(blk_a);
        wr(blk_b);
        rd(1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        wr(blk_c);
        rd(4);

        wr(blk_a);
        wr(blk_b);
        rd(1);
        reset_mid();
        wr(blk_c);
        rd(4);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end
        rd(4 * DEPTH + 1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
